// File: rtl/hann_overlap_framer.sv
// -----------------------------------------------------------------------------
// hann_overlap_framer
//
// Collects a continuous signed sample stream into overlapping frames of
// FRAME_LEN samples (advancing HOP samples per frame) and replays each frame
// oldest-first as an unbroken burst, either Hann-windowed or rectangular.
// Intended to feed an FFT/IFFT chain directly.
//
// Ports:
//   clk         in   clock
//   reset       in   asynchronous, active-low reset
//   in_valid    in   in_data carries a sample this cycle (no backpressure)
//   in_data     in   signed input sample, DATA_W bits
//   win_en      in   1 = Hann window, 0 = rectangular; sampled at frame trigger
//   out_valid   out  out_data is valid
//   out_data    out  signed windowed sample, DATA_W bits
//   out_sof     out  first sample of a frame (qualified by out_valid)
//   out_eof     out  last sample of a frame (qualified by out_valid)
//   overrun     out  sticky: a frame trigger arrived while a burst was active
//   dbg_state_o out  read-side FSM state (1 = EMIT), for checkers
//
// Handshake: the input is valid-only; every cycle with in_valid high is one
// accepted sample. The output is valid-only; out_valid high marks one output
// sample, with out_sof/out_eof meaningful only while out_valid is high.
// -----------------------------------------------------------------------------
module hann_overlap_framer #(
    parameter int DATA_W    = 32,
    parameter int FRAME_LEN = 32,
    parameter int HOP       = 16,
    parameter int COEF_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              win_en,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sof,
    output logic              out_eof,
    output logic              overrun,
    output logic              dbg_state_o
);

    localparam int  AW    = $clog2(2 * FRAME_LEN);
    localparam int  IW    = $clog2(FRAME_LEN);
    localparam int  FW    = $clog2(FRAME_LEN + 1);
    localparam int  HW    = $clog2(HOP + 1);
    localparam int  PW    = DATA_W + COEF_W + 1;
    localparam real PI    = 3.14159265358979323846;

    localparam logic signed [PW-1:0] RND = PW'(1) << (COEF_W - 2);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Periodic Hann ROM, evaluated at elaboration.
    // ------------------------------------------------------------------
    logic [COEF_W-1:0] coef_rom [FRAME_LEN];

    for (genvar i = 0; i < FRAME_LEN; i++) begin : g_rom
        localparam real ANGLE = 2.0 * PI * i / FRAME_LEN;
        localparam real HANN  = 0.5 * (1.0 - $cos(ANGLE));
        localparam int  COEF  = $rtoi(HANN * (2.0 ** (COEF_W - 1)) + 0.5);
        assign coef_rom[i] = COEF_W'(COEF);
    end

    // ------------------------------------------------------------------
    // Sample storage. Depth 2*FRAME_LEN keeps a frame intact while it is
    // replayed, even with a new sample arriving every cycle.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [2*FRAME_LEN];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [FW-1:0]     fill_q;
    logic [HW-1:0]     hop_q;
    logic              busy_q;
    logic              overrun_q;

    state_t            state_q;
    logic [IW-1:0]     idx_q;
    logic [AW-1:0]     start_q;
    logic              win_q;

    // Stage 1: buffer/ROM read.
    logic              s1_valid_q;
    logic [DATA_W-1:0] s1_data_q;
    logic [COEF_W-1:0] s1_coef_q;
    logic              s1_sof_q;
    logic              s1_last_q;
    logic              s1_win_q;

    // ------------------------------------------------------------------
    // Trigger detection
    // ------------------------------------------------------------------
    logic              primed;
    logic              first_hit;
    logic              hop_hit;
    logic              trig;
    logic              frame_done;
    logic              accept;
    logic [AW-1:0]     frame_start;
    logic [AW-1:0]     rd_addr;

    always_comb begin
        primed      = (fill_q == FW'(FRAME_LEN));
        first_hit   = in_valid && !primed && ((fill_q + FW'(1)) == FW'(FRAME_LEN));
        hop_hit     = in_valid && primed && ((hop_q + HW'(1)) == HW'(HOP));
        trig        = first_hit || hop_hit;
        // The burst's eof is being registered on this edge, so the burst
        // is over as far as a new trigger is concerned.
        frame_done  = s1_valid_q && s1_last_q;
        accept      = trig && (!busy_q || frame_done);
        wr_ptr_d    = in_valid ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        // (wr_ptr after this write) - FRAME_LEN, modulo 2*FRAME_LEN;
        // subtracting FRAME_LEN equals adding it in this ring.
        frame_start = wr_ptr_q + AW'(FRAME_LEN + 1);
        rd_addr     = start_q + AW'(idx_q);
    end

    always_ff @(posedge clk) begin
        if (in_valid) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // ------------------------------------------------------------------
    // Fill / hop counters, busy and sticky overrun
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            fill_q    <= '0;
            hop_q     <= '0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            if (in_valid) begin
                if (!primed) begin
                    fill_q <= fill_q + FW'(1);
                end else if (hop_hit) begin
                    hop_q <= '0;
                end else begin
                    hop_q <= hop_q + HW'(1);
                end
            end
            if (accept) begin
                busy_q <= 1'b1;
            end else if (frame_done) begin
                busy_q <= 1'b0;
            end
            if (trig && !accept) begin
                overrun_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read-side FSM: walks n = 0..FRAME_LEN-1 one per cycle and loads the
    // stage-1 registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            start_q    <= '0;
            win_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_coef_q  <= '0;
            s1_sof_q   <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_win_q   <= 1'b0;
        end else begin
            s1_valid_q <= (state_q == ST_EMIT);
            s1_data_q  <= mem_q[rd_addr];
            s1_coef_q  <= coef_rom[idx_q];
            s1_sof_q   <= (state_q == ST_EMIT) && (idx_q == '0);
            s1_last_q  <= (state_q == ST_EMIT) && (idx_q == IW'(FRAME_LEN - 1));
            s1_win_q   <= win_q;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q <= ST_EMIT;
                        idx_q   <= '0;
                        start_q <= frame_start;
                        win_q   <= win_en;
                    end
                end
                ST_EMIT: begin
                    idx_q <= idx_q + IW'(1);
                    if (idx_q == IW'(FRAME_LEN - 1)) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: windowing multiply with round-half-up, then output register.
    // The coefficient is zero-extended so the multiply is signed x unsigned.
    // ------------------------------------------------------------------
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] prod_rnd;
    logic signed [PW-1:0] prod_sh;
    logic [DATA_W-1:0]    win_val;

    always_comb begin
        prod     = PW'($signed(s1_data_q)) * PW'($signed({1'b0, s1_coef_q}));
        prod_rnd = prod + RND;
        prod_sh  = prod_rnd >>> (COEF_W - 1);
        win_val  = DATA_W'(prod_sh);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
        end else begin
            out_valid <= s1_valid_q;
            out_data  <= s1_valid_q ? (s1_win_q ? win_val : s1_data_q) : '0;
            out_sof   <= s1_valid_q && s1_sof_q;
            out_eof   <= s1_valid_q && s1_last_q;
        end
    end

    assign overrun     = overrun_q;
    assign dbg_state_o = (state_q == ST_EMIT);

endmodule

// File: tb/tb_hann_overlap_framer.sv
// -----------------------------------------------------------------------------
// tb_hann_overlap_framer
//
// Bench for hann_overlap_framer with FRAME_LEN=8, HOP=4, COEF_W=16, DATA_W=32.
// A reference model of the fill/hop/busy rules pushes every expected output
// sample (data, sof, eof, output cycle) into queues as stimulus is driven; a
// negedge monitor pops and compares whatever the DUT emits.
// -----------------------------------------------------------------------------
module tb_hann_overlap_framer;

    localparam int DATA_W = 32;
    localparam int FL     = 8;
    localparam int HOP    = 4;
    localparam int COEF_W = 16;

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              win_en = 1'b0;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_sof;
    logic              out_eof;
    logic              overrun;
    logic              dbg_state_o;

    always #5 clk = ~clk;

    hann_overlap_framer #(
        .DATA_W   (DATA_W),
        .FRAME_LEN(FL),
        .HOP      (HOP),
        .COEF_W   (COEF_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .win_en     (win_en),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_sof    (out_sof),
        .out_eof    (out_eof),
        .overrun    (overrun),
        .dbg_state_o(dbg_state_o)
    );

    // ---------------- scoreboard state ----------------
    int                n_vec = 0;
    int                n_err = 0;
    longint            cyc = 0;
    int                out_cnt = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic              exp_sof_q[$];
    logic              exp_eof_q[$];
    longint            exp_cyc_q[$];

    // Reference model state
    int                fill_m = 0;
    int                hop_m = 0;
    longint            busy_until = 0;
    logic              exp_overrun = 1'b0;
    logic [DATA_W-1:0] hist[$];

    int coef_ref [FL] = '{0, 4799, 16384, 27969, 32768, 27969, 16384, 4799};

    function automatic logic [DATA_W-1:0] hann_ref(input logic [DATA_W-1:0] s, input int n);
        longint p;
        p = longint'($signed(s)) * longint'(coef_ref[n]) + 64'sd16384;
        return DATA_W'(p >>> 15);
    endfunction

    task automatic flush_sb();
        exp_q.delete();
        exp_sof_q.delete();
        exp_eof_q.delete();
        exp_cyc_q.delete();
    endtask

    task automatic model_reset();
        fill_m      = 0;
        hop_m       = 0;
        busy_until  = 0;
        exp_overrun = 1'b0;
        hist.delete();
    endtask

    // Apply the fill/hop/busy rules to one accepted sample at edge c.
    task automatic model_accept(input logic [DATA_W-1:0] d, input logic w, input longint c);
        logic t;
        logic [DATA_W-1:0] s;
        t = 1'b0;
        hist.push_back(d);
        if (fill_m < FL) begin
            fill_m++;
            if (fill_m == FL) t = 1'b1;
        end else begin
            hop_m++;
            if (hop_m == HOP) begin
                hop_m = 0;
                t = 1'b1;
            end
        end
        if (t) begin
            if (c >= busy_until) begin
                busy_until = c + FL + 1;
                for (int n = 0; n < FL; n++) begin
                    s = hist[hist.size() - FL + n];
                    exp_q.push_back(w ? hann_ref(s, n) : s);
                    exp_sof_q.push_back(n == 0);
                    exp_eof_q.push_back(n == FL - 1);
                    exp_cyc_q.push_back(c + 2 + n);
                end
            end else begin
                exp_overrun = 1'b1;
            end
        end
    endtask

    // ---------------- driver ----------------
    // One call = one clock cycle. Inputs change on the falling edge.
    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic w);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        win_en   = w;
        @(posedge clk);
        cyc++;
        if (v && reset) model_accept(d, w, cyc);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        flush_sb();
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 200 && exp_q.size() > 0; t++) step(1'b0, '0, win_en);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: %0d outputs still outstanding, required 0", name, exp_q.size());
            flush_sb();
        end
        repeat (3) step(1'b0, '0, win_en);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [DATA_W-1:0] ed;
        logic es, ee;
        longint ec;
        if (reset && out_valid) begin
            out_cnt++;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_out: out_data=%0d at cycle %0d, required no output",
                         $signed(out_data), cyc);
            end else begin
                ed = exp_q.pop_front();
                es = exp_sof_q.pop_front();
                ee = exp_eof_q.pop_front();
                ec = exp_cyc_q.pop_front();
                if (out_data !== ed) begin
                    n_err++;
                    $display("FAIL out_data: got %0d, required %0d (cycle %0d)",
                             $signed(out_data), $signed(ed), cyc);
                end
                n_vec++;
                if (out_sof !== es) begin
                    n_err++;
                    $display("FAIL out_sof: got %0b, required %0b (cycle %0d)", out_sof, es, cyc);
                end
                n_vec++;
                if (out_eof !== ee) begin
                    n_err++;
                    $display("FAIL out_eof: got %0b, required %0b (cycle %0d)", out_eof, ee, cyc);
                end
                n_vec++;
                if (cyc != ec) begin
                    n_err++;
                    $display("FAIL out_timing: output at cycle %0d, required cycle %0d", cyc, ec);
                end
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        n_vec++;
        if (out_sof !== 1'b0 || out_eof !== 1'b0) begin
            n_err++; $display("FAIL reset_sof_eof: got %b/%b, required 0/0", out_sof, out_eof);
        end
        n_vec++;
        if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b, required 0", overrun); end
        n_vec++;
        if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data: got %0d, required 0", out_data); end
        n_vec++;
        if (dbg_state_o !== 1'b0) begin n_err++; $display("FAIL reset_state: got %b, required 0", dbg_state_o); end
        flush_sb();
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_hann_pos();
        do_reset();
        for (int i = 0; i < FL; i++) begin
            n_vec++;
            if (dut.coef_rom[i] !== 16'(coef_ref[i])) begin
                n_err++;
                $display("FAIL coef_rom[%0d]: got %0d, required %0d", i, dut.coef_rom[i], coef_ref[i]);
            end
        end
        for (int i = 0; i < FL; i++) begin
            step(1'b1, 32'd1000, 1'b1);
            repeat (7) step(1'b0, '0, 1'b1);
        end
        drain("hann_pos");
        n_vec++;
        if (overrun !== exp_overrun) begin
            n_err++; $display("FAIL hann_pos_overrun: got %b, required %b", overrun, exp_overrun);
        end
    endtask

    task automatic test_hann_neg();
        do_reset();
        for (int i = 0; i < FL; i++) begin
            step(1'b1, -32'sd1000, 1'b1);
            repeat (7) step(1'b0, '0, 1'b1);
        end
        drain("hann_neg");
    endtask

    task automatic test_rect_spaced();
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, DATA_W'(i), 1'b0);
            step(1'b0, '0, 1'b0);
            step(1'b0, '0, 1'b0);
        end
        drain("rect_spaced");
        n_vec++;
        if (overrun !== 1'b0) begin n_err++; $display("FAIL rect_spaced_overrun: got %b, required 0", overrun); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 1; i <= 24; i++) begin
            step(1'b1, DATA_W'(i), 1'b0);
            n_vec++;
            if (overrun !== exp_overrun) begin
                n_err++;
                $display("FAIL b2b_overrun: after sample %0d got %b, required %b", i, overrun, exp_overrun);
            end
        end
        drain("b2b");
        n_vec++;
        if (overrun !== 1'b1) begin n_err++; $display("FAIL b2b_overrun_sticky: got %b, required 1", overrun); end
    endtask

    // Runs straight after test_back_to_back so overrun is still set.
    task automatic test_reset_mid();
        int base;
        base = out_cnt;
        for (int i = 25; i <= 28; i++) step(1'b1, DATA_W'(i), 1'b0);
        for (int t = 0; t < 50 && out_cnt < base + 3; t++) step(1'b0, '0, 1'b0);
        n_vec++;
        if (out_cnt < base + 3) begin
            n_err++; $display("FAIL reset_mid_wait: got %0d outputs, required 3", out_cnt - base);
        end
        n_vec++;
        if (overrun !== 1'b1) begin n_err++; $display("FAIL reset_mid_pre_overrun: got %b, required 1", overrun); end
        #1;
        reset = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_mid_valid: got %b, required 0", out_valid); end
        n_vec++;
        if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_mid_overrun: got %b, required 0", overrun); end
        flush_sb();
        model_reset();
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        base = out_cnt;
        for (int i = 0; i < 7; i++) step(1'b1, DATA_W'(100 + i), 1'b0);
        repeat (10) step(1'b0, '0, 1'b0);
        n_vec++;
        if (out_cnt != base) begin
            n_err++; $display("FAIL reset_mid_refill: got %0d outputs after 7 samples, required 0", out_cnt - base);
        end
        step(1'b1, DATA_W'(107), 1'b0);
        drain("reset_mid");
        n_vec++;
        if (out_cnt != base + FL) begin
            n_err++; $display("FAIL reset_mid_frame: got %0d outputs, required %0d", out_cnt - base, FL);
        end
    endtask

    task automatic test_win_toggle();
        logic [DATA_W-1:0] d;
        do_reset();
        for (int i = 0; i < FL; i++) begin
            d = DATA_W'($urandom_range(0, 200000)) - DATA_W'(100000);
            step(1'b1, d, 1'b1);
        end
        // win_en flips every cycle during the windowed burst
        for (int t = 0; t < 12; t++) step(1'b0, '0, t[0]);
        for (int i = 0; i < HOP; i++) begin
            d = DATA_W'($urandom_range(0, 200000)) - DATA_W'(100000);
            step(1'b1, d, 1'b0);
        end
        drain("win_toggle");
    endtask

    initial begin
        test_reset();
        test_hann_pos();
        test_hann_neg();
        test_rect_spaced();
        test_back_to_back();
        test_reset_mid();
        test_win_toggle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
